// File: rtl/clock_control.sv
// Run/stop/single-step controller producing the divided CPU clock from the board oscillator.
// Define CLOCK_CONTROL_CYCLE_COUNT_EN to add o_cycles, a count of o_clk rising edges.
module clock_control #(
  parameter int DIV_WIDTH       = 24,
  parameter int DEFAULT_DIV     = 130000,
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run_btn,
  input  logic                 i_step_btn,
  input  logic                 i_cpu_halt,
  input  logic                 i_div_load,
  input  logic [DIV_WIDTH-1:0] i_div_value,
  output logic                 o_clk,
  output logic                 o_running,
  output logic                 o_halted,
  output logic                 o_step_done
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
  ,
  output logic [31:0]          o_cycles
`endif
);

  typedef enum logic [2:0] {STOPPED, RUN, DRAIN, STEP, HALTED} state_t;

  localparam logic [15:0]          DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

  // bit 0 = Run button, bit 1 = Step button
  logic [1:0]  sync1, sync2, level, level_q;
  logic [15:0] db_cnt [2];
  logic        run_ev, step_ev;

  state_t               state, state_nxt;
  logic                 clk_nxt, halt_tgt, halt_tgt_nxt, done_nxt, stop_halt, tick;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt, div, div_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_q   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= {i_step_btn, i_run_btn};
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign run_ev  = level[0] & ~level_q[0];
  assign step_ev = level[1] & ~level_q[1];

  // A load restarts the current phase, so it also suppresses a toggle due this cycle.
  assign tick      = (cnt == div - ONE) && !i_div_load;
  assign stop_halt = halt_tgt | i_cpu_halt;

  always_comb begin
    state_nxt    = state;
    clk_nxt      = o_clk;
    cnt_nxt      = cnt + ONE;
    div_nxt      = div;
    halt_tgt_nxt = halt_tgt;
    done_nxt     = 1'b0;
    case (state)
      STOPPED: begin
        clk_nxt = 1'b0;
        cnt_nxt = '0;
        if (run_ev) begin
          state_nxt = RUN;
        end else if (step_ev) begin
          state_nxt    = STEP;
          clk_nxt      = 1'b1;
          halt_tgt_nxt = 1'b0;
        end
      end
      RUN: begin
        if ((run_ev || i_cpu_halt) && !o_clk) begin
          state_nxt = i_cpu_halt ? HALTED : STOPPED;
          cnt_nxt   = '0;
        end else if (run_ev || i_cpu_halt) begin
          // high phase is never truncated: finish it in DRAIN unless it ends right now
          halt_tgt_nxt = i_cpu_halt;
          if (tick) begin
            clk_nxt   = 1'b0;
            cnt_nxt   = '0;
            state_nxt = i_cpu_halt ? HALTED : STOPPED;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (tick) begin
          clk_nxt = !o_clk;
          cnt_nxt = '0;
        end
      end
      DRAIN: begin
        halt_tgt_nxt = stop_halt;
        if (tick) begin
          clk_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = stop_halt ? HALTED : STOPPED;
        end
      end
      STEP: begin
        halt_tgt_nxt = stop_halt;
        if (tick) begin
          cnt_nxt = '0;
          if (o_clk) begin
            clk_nxt = 1'b0;
          end else begin
            state_nxt = stop_halt ? HALTED : STOPPED;
            done_nxt  = !stop_halt;
          end
        end
      end
      HALTED: begin
        clk_nxt = 1'b0;
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = STOPPED;
        clk_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
    if (i_div_load) begin
      div_nxt = (i_div_value == '0) ? ONE : i_div_value;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= STOPPED;
      o_clk       <= 1'b0;
      cnt         <= '0;
      div         <= DIV_RESET;
      halt_tgt    <= 1'b0;
      o_step_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_clk       <= clk_nxt;
      cnt         <= cnt_nxt;
      div         <= div_nxt;
      halt_tgt    <= halt_tgt_nxt;
      o_step_done <= done_nxt;
    end
  end

  assign o_running = (state == RUN) || (state == DRAIN);
  assign o_halted  = (state == HALTED);

`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycles <= '0;
    end else if (clk_nxt && !o_clk) begin
      o_cycles <= o_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_control.sv
// Bench for clock_control: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a phase-countdown behavioural model.
module tb_clock_control;
  localparam int DW   = 24;
  localparam int DIV0 = 3;
  localparam int DEB  = 4;
  localparam int M_STOPPED = 0, M_RUN = 1, M_DRAIN = 2, M_STEP = 3, M_HALTED = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_run_btn = 1'b0, i_step_btn = 1'b0, i_cpu_halt = 1'b0, i_div_load = 1'b0;
  logic [DW-1:0] i_div_value = '0;
  logic          o_clk, o_running, o_halted, o_step_done;
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
  logic [31:0]   o_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  clock_control #(.DIV_WIDTH(DW), .DEFAULT_DIV(DIV0), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run_btn(i_run_btn), .i_step_btn(i_step_btn),
    .i_cpu_halt(i_cpu_halt), .i_div_load(i_div_load), .i_div_value(i_div_value),
    .o_clk(o_clk), .o_running(o_running), .o_halted(o_halted), .o_step_done(o_step_done)
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
    , .o_cycles(o_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (time %0t, t=%0d): got %b, expected %b", name, $time, t, act, exp);
    end
  endtask

  // Behavioural model: raw -> two-sample delay -> window debouncer; clock as phase countdown.
  int        m_mode, m_div, m_left;
  bit        m_clk, m_done, m_tgt, m_sh;
  bit [31:0] m_cycles;
  bit        s1 [2], s2 [2], lvl [2], lvlp [2];
  bit        hist [2][DEB];

  task automatic model_reset();
    m_mode = M_STOPPED; m_clk = 0; m_done = 0; m_tgt = 0; m_sh = 0;
    m_div = DIV0; m_left = 0; m_cycles = 0;
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; lvl[b] = 0; lvlp[b] = 0;
      for (int k = 0; k < DEB; k++) hist[b][k] = 0;
    end
  endtask

  task automatic advance();
    m_left--;
    if (m_left == 0) begin
      m_clk  = !m_clk;
      m_left = m_div;
    end
  endtask

  task automatic model_step();
    bit ev_run, ev_step, halt, load, old_clk, diff;
    bit raw [2];
    int nd;
    ev_run  = lvl[0] && !lvlp[0];
    ev_step = lvl[1] && !lvlp[1];
    halt    = i_cpu_halt;
    load    = i_div_load;
    nd      = (i_div_value == '0) ? 1 : int'(i_div_value);
    raw[0]  = i_run_btn;
    raw[1]  = i_step_btn;
    for (int b = 0; b < 2; b++) begin
      lvlp[b] = lvl[b];
      for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = s2[b];
      diff = 1;
      for (int k = 0; k < DEB; k++) if (hist[b][k] == lvl[b]) diff = 0;
      if (diff) lvl[b] = s2[b];
      s2[b] = s1[b];
      s1[b] = raw[b];
    end
    old_clk = m_clk;
    m_done  = 0;
    case (m_mode)
      M_STOPPED: begin
        m_clk = 0;
        if (ev_run) begin
          m_mode = M_RUN; m_left = m_div;
        end else if (ev_step) begin
          m_mode = M_STEP; m_clk = 1; m_left = m_div; m_sh = 0;
        end
      end
      M_RUN: begin
        if ((ev_run || halt) && !m_clk) begin
          m_mode = halt ? M_HALTED : M_STOPPED;
        end else begin
          if (ev_run || halt) begin
            m_tgt = halt; m_mode = M_DRAIN;
          end
          if (!load) advance();
          if (m_mode == M_DRAIN && !m_clk) m_mode = m_tgt ? M_HALTED : M_STOPPED;
        end
      end
      M_DRAIN: begin
        m_tgt = m_tgt | halt;
        if (!load) advance();
        if (!m_clk) m_mode = m_tgt ? M_HALTED : M_STOPPED;
      end
      M_STEP: begin
        m_sh = m_sh | halt;
        if (!load) begin
          m_left--;
          if (m_left == 0) begin
            if (m_clk) begin
              m_clk = 0; m_left = m_div;
            end else begin
              m_mode = m_sh ? M_HALTED : M_STOPPED;
              m_done = !m_sh;
            end
          end
        end
      end
      default: m_clk = 0;
    endcase
    if (load) begin
      m_div = nd; m_left = nd;
    end
    if (m_clk && !old_clk) m_cycles = m_cycles + 1;
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) model_reset();
    else model_step();
  end

  always @(negedge i_clk) begin
    chk("model_o_clk", o_clk, m_clk);
    chk("model_o_running", o_running, (m_mode == M_RUN) || (m_mode == M_DRAIN));
    chk("model_o_halted", o_halted, m_mode == M_HALTED);
    chk("model_o_step_done", o_step_done, m_done);
`ifdef CLOCK_CONTROL_CYCLE_COUNT_EN
    n_cmp++;
    if (o_cycles !== m_cycles) begin
      n_bad++;
      $display("FAIL model_o_cycles (time %0t): got %0d, expected %0d", $time, o_cycles, m_cycles);
    end
`endif
  end

  task automatic tk();
    @(posedge i_clk);
    #1;
    t++;
  endtask

  task automatic to(input int k);
    while (t < k) tk();
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("reset_clk", o_clk, 1'b0);
    chk("reset_running", o_running, 1'b0);
    chk("reset_halted", o_halted, 1'b0);
    chk("reset_step_done", o_step_done, 1'b0);

    // short glitch never reaches the debounced level
    t = 0; i_run_btn = 1; to(2); i_run_btn = 0; to(14);
    chk("glitch_running", o_running, 1'b0);
    chk("glitch_clk", o_clk, 1'b0);

    // single step: 3 high, 3 low, one done pulse
    t = 0; i_step_btn = 1; to(5); i_step_btn = 0;
    to(7);  chk("step_high_start", o_clk, 1'b1);
    to(9);  chk("step_high_end", o_clk, 1'b1);
    to(10); chk("step_low_start", o_clk, 1'b0);
    to(12); chk("step_done_early", o_step_done, 1'b0);
    to(13); chk("step_done_pulse", o_step_done, 1'b1); chk("step_not_running", o_running, 1'b0);
    to(14); chk("step_done_once", o_step_done, 1'b0);
    to(25);

    // run press: RUN 7 cycles after press, first rise 3 cycles later
    t = 0; i_run_btn = 1;
    to(6);  chk("run_not_yet", o_running, 1'b0);
    to(7);  chk("run_started", o_running, 1'b1);
    to(9);  chk("run_first_low", o_clk, 1'b0);
    to(10); chk("run_first_rise", o_clk, 1'b1);
    to(12); i_run_btn = 0;
    to(13); chk("run_first_fall", o_clk, 1'b0);
    // half-period reload to 5, then 0 (treated as 1), then back to 3
    to(17); i_div_load = 1; i_div_value = 5; to(18); i_div_load = 0;
    to(22); chk("div5_still_high", o_clk, 1'b1);
    to(23); chk("div5_fall", o_clk, 1'b0);
    to(27); chk("div5_low_held", o_clk, 1'b0);
    to(28); chk("div5_rise", o_clk, 1'b1);
    i_div_load = 1; i_div_value = 0; to(29); i_div_load = 0;
    chk("div0_load_keeps_clk", o_clk, 1'b1);
    to(30); chk("div0_fall", o_clk, 1'b0);
    to(31); chk("div0_rise", o_clk, 1'b1);
    i_div_load = 1; i_div_value = 3; to(32); i_div_load = 0;
    // stop press lands one cycle into the high phase that starts at 44
    to(38); i_run_btn = 1; to(44); i_run_btn = 0;
    chk("drain_high_start", o_clk, 1'b1);
    to(46); chk("drain_high_kept", o_clk, 1'b1); chk("drain_running", o_running, 1'b1);
    to(47); chk("drain_fall", o_clk, 1'b0); chk("drain_stopped", o_running, 1'b0);
    to(52); chk("stopped_no_toggle", o_clk, 1'b0);

    // halt during a high phase completes at the scheduled falling edge
    t = 0; i_run_btn = 1; to(6); i_run_btn = 0;
    to(7);  chk("halt_run_started", o_running, 1'b1);
    to(58); i_cpu_halt = 1; to(59); i_cpu_halt = 0;
    to(60); chk("halt_high_kept", o_clk, 1'b1); chk("halt_not_yet", o_halted, 1'b0);
    to(61); chk("halt_reached", o_halted, 1'b1); chk("halt_clk_low", o_clk, 1'b0);
    i_run_btn = 1; i_step_btn = 1; to(75); i_run_btn = 0; i_step_btn = 0; to(85);
    chk("halt_ignores_buttons", o_halted, 1'b1);
    chk("halt_clk_stays_low", o_clk, 1'b0);
    i_rst_n = 0; #1;
    chk("rst_clears_halt", o_halted, 1'b0);
    tk(); i_rst_n = 1;

    // random sessions
    for (int s = 0; s < 8; s++) begin
      i_rst_n = 0; i_run_btn = 0; i_step_btn = 0; i_cpu_halt = 0; i_div_load = 0;
      tk(); tk(); i_rst_n = 1;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 7) == 0) i_run_btn = !i_run_btn;
        if ($urandom_range(0, 9) == 0) i_step_btn = !i_step_btn;
        i_cpu_halt  = ($urandom_range(0, 150) == 0);
        i_div_load  = ($urandom_range(0, 40) == 0);
        i_div_value = DW'($urandom_range(0, 5));
        tk();
      end
    end
    i_div_load = 0; i_cpu_halt = 0;
    tk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_control.md
Name: clock_control

Overview:
- Run/stop/single-step controller for the CPU system clock.
- Takes the board oscillator, debounces the front-panel Run and Step buttons, and honours the CPU halt request.
- Generates the divided CPU clock with a runtime-loadable half-period.
- Sits between the board inputs and the CPU core; replaces the free-running divider as the single source of the CPU clock.

Parameters:
DIV_WIDTH, 24, width of the half-period register and counter
DEFAULT_DIV, 130000, reset value of the half-period, in i_clk cycles
DEBOUNCE_CYCLES, 65535, cycles an input must hold stable to be accepted; 16-bit counter

Ports:
i_clk  in  1  board oscillator; all logic on its rising edge
i_rst_n  in  1  asynchronous active-low reset
i_run_btn  in  1  raw Run button, active high, asynchronous
i_step_btn  in  1  raw Step button, active high, asynchronous
i_cpu_halt  in  1  halt request from the CPU (HLT executed), synchronous to i_clk
i_div_load  in  1  one-cycle strobe; load i_div_value as the new half-period
i_div_value  in  DIV_WIDTH  new half-period; 0 is treated as 1
o_clk  out  1  CPU clock
o_running  out  1  high in RUN or DRAIN
o_halted  out  1  high in HALTED
o_step_done  out  1  one-cycle pulse when a single step completes

Behaviour:
- Reset (asynchronous): state STOPPED; o_clk=0; counter=0; div=DEFAULT_DIV; debounced levels=0; all outputs 0.
- Button path:
  - 2-FF synchroniser, then debouncer.
  - Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle event (run_ev, step_ev).
- Divider:
  - Counter increments every cycle while the phase generator is active.
  - When counter==div-1: o_clk toggles and counter clears.
  - Each phase therefore lasts exactly div cycles; period is 2*div.
- i_div_load:
  - div <= max(i_div_value,1); counter cleared; o_clk unchanged.
  - The next toggle occurs div cycles after the load.
- States:
  - STOPPED:
    - o_clk=0, counter held 0.
    - run_ev -> RUN.
    - else step_ev -> STEP. run_ev has priority when simultaneous; the step is discarded.
  - RUN:
    - Free-running toggling.
    - run_ev or i_cpu_halt with o_clk=0 -> STOPPED/HALTED next cycle; counter cleared.
    - The same events with o_clk=1 -> DRAIN, recording the target.
  - DRAIN:
    - Continues counting until the scheduled falling edge (high phase never truncated).
    - Then goes to the target (STOPPED or HALTED) with o_clk=0.
    - i_cpu_halt arriving in DRAIN upgrades the target to HALTED.
  - STEP:
    - o_clk=1 for div cycles, then 0 for div cycles.
    - Then STOPPED with o_step_done=1 for that one cycle.
    - i_cpu_halt seen during STEP -> HALTED at step end; no o_step_done.
  - HALTED:
    - o_clk=0; terminal until reset.
    - run_ev and step_ev are ignored.
- Events ignored where not listed: step_ev in RUN/DRAIN/STEP; run_ev in DRAIN/STEP.
- o_clk is a registered output, glitch-free.

Optional Feature:
CLOCK_CONTROL_CYCLE_COUNT_EN:
- Defined: adds output port o_cycles[31:0] counting rising edges of o_clk.
  - Reset to 0.
  - Wraps 0xFFFFFFFF -> 0.
  - Counts in every state.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
Bench parameters throughout: DEFAULT_DIV=3, DEBOUNCE_CYCLES=4.
1. Reset, then hold i_run_btn high 12 cycles -> run_ev 7 cycles after press (2 sync + 4 debounce + 1); o_running=1; o_clk toggles every 3 cycles.
2. 2-cycle glitch on i_run_btn in STOPPED -> no event; o_clk stays 0; o_running=0.
3. Step press in STOPPED -> o_clk high exactly 3 cycles, low 3; o_step_done pulses once; state STOPPED; a second step press during the step is ignored.
4. RUN, then run press debounced 1 cycle into a high phase -> high phase still lasts 3 cycles, then o_clk=0, o_running=0, no further toggles.
5. RUN, then assert i_cpu_halt -> o_halted=1 at the next scheduled falling edge; run/step presses ignored; i_rst_n low clears o_halted immediately.
6. RUN with div=3, then i_div_load with i_div_value=5 -> next toggle 5 cycles after the load, 5-cycle phases thereafter; i_div_value=0 -> 1-cycle phases.
